// File: rtl/lcd_spi_stream.sv
// ST7789-class SPI LCD controller: power-up reset, sleep-out, register init, then per-frame window + RGB565 stream.
// Optional LCD_TEST_PATTERN_EN replaces the pixel input with internally generated colour bars.
module lcd_spi_stream #(
    parameter int CLK_DIV     = 1,
    parameter int H_RES       = 240,
    parameter int V_RES       = 135,
    parameter int X_OFS       = 40,
    parameter int Y_OFS       = 53,
    parameter int CNT_RESET   = 2700000,
    parameter int CNT_PREPARE = 5400000,
    parameter int CNT_SLEEP   = 3240000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic        init_done,
    output logic        lcd_resetn,
    output logic        lcd_clk,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_data
);

    localparam int TOTAL   = H_RES * V_RES;
    localparam int PW      = $clog2(TOTAL + 1);
    localparam int CNT_M1  = (CNT_RESET > CNT_PREPARE) ? CNT_RESET : CNT_PREPARE;
    localparam int CNT_MAX = (CNT_M1 > CNT_SLEEP) ? CNT_M1 : CNT_SLEEP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] RESET_LAST   = CW'(CNT_RESET - 1);
    localparam logic [CW-1:0] PREPARE_LAST = CW'(CNT_PREPARE - 1);
    localparam logic [CW-1:0] SLEEP_LAST   = CW'(CNT_SLEEP - 1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PIX_TOTAL    = PW'(TOTAL);
    localparam logic [PW-1:0] PIX_LAST     = PW'(TOTAL - 1);
    localparam logic [15:0]   XS = 16'(X_OFS);
    localparam logic [15:0]   XE = 16'(X_OFS + H_RES - 1);
    localparam logic [15:0]   YS = 16'(Y_OFS);
    localparam logic [15:0]   YE = 16'(Y_OFS + V_RES - 1);
    localparam logic [5:0]    INIT_LEN = 6'd59;
    localparam logic [5:0]    WIN_LEN  = 6'd11;

    localparam logic [2:0] RST_HOLD   = 3'd0;
    localparam logic [2:0] RST_WAIT   = 3'd1;
    localparam logic [2:0] WAKE       = 3'd2;
    localparam logic [2:0] SLEEP_WAIT = 3'd3;
    localparam logic [2:0] INIT       = 3'd4;
    localparam logic [2:0] WINDOW     = 3'd5;
    localparam logic [2:0] STREAM     = 3'd6;

    localparam logic [2:0] E_IDLE = 3'd0;
    localparam logic [2:0] E_LOW  = 3'd1;
    localparam logic [2:0] E_HIGH = 3'd2;
    localparam logic [2:0] E_TAIL = 3'd3;
    localparam logic [2:0] E_GAP  = 3'd4;

    // Init ROM entries are {dc, byte}; dc=0 marks a command byte.
    function automatic logic [8:0] init_rom(input logic [5:0] i);
        case (i)
            6'd0:  init_rom = 9'h036; 6'd1:  init_rom = 9'h170; 6'd2:  init_rom = 9'h03A; 6'd3:  init_rom = 9'h105;
            6'd4:  init_rom = 9'h0B2; 6'd5:  init_rom = 9'h10C; 6'd6:  init_rom = 9'h10C; 6'd7:  init_rom = 9'h100;
            6'd8:  init_rom = 9'h133; 6'd9:  init_rom = 9'h133; 6'd10: init_rom = 9'h0B7; 6'd11: init_rom = 9'h135;
            6'd12: init_rom = 9'h0BB; 6'd13: init_rom = 9'h119; 6'd14: init_rom = 9'h0C0; 6'd15: init_rom = 9'h12C;
            6'd16: init_rom = 9'h0C2; 6'd17: init_rom = 9'h101; 6'd18: init_rom = 9'h0C3; 6'd19: init_rom = 9'h112;
            6'd20: init_rom = 9'h0C4; 6'd21: init_rom = 9'h120; 6'd22: init_rom = 9'h0C6; 6'd23: init_rom = 9'h10F;
            6'd24: init_rom = 9'h0D0; 6'd25: init_rom = 9'h1A4; 6'd26: init_rom = 9'h1A1; 6'd27: init_rom = 9'h0E0;
            6'd28: init_rom = 9'h1D0; 6'd29: init_rom = 9'h104; 6'd30: init_rom = 9'h10D; 6'd31: init_rom = 9'h111;
            6'd32: init_rom = 9'h113; 6'd33: init_rom = 9'h12B; 6'd34: init_rom = 9'h13F; 6'd35: init_rom = 9'h154;
            6'd36: init_rom = 9'h14C; 6'd37: init_rom = 9'h118; 6'd38: init_rom = 9'h10D; 6'd39: init_rom = 9'h10B;
            6'd40: init_rom = 9'h11F; 6'd41: init_rom = 9'h123; 6'd42: init_rom = 9'h0E1; 6'd43: init_rom = 9'h1D0;
            6'd44: init_rom = 9'h104; 6'd45: init_rom = 9'h10C; 6'd46: init_rom = 9'h111; 6'd47: init_rom = 9'h113;
            6'd48: init_rom = 9'h12C; 6'd49: init_rom = 9'h13F; 6'd50: init_rom = 9'h144; 6'd51: init_rom = 9'h151;
            6'd52: init_rom = 9'h12F; 6'd53: init_rom = 9'h11F; 6'd54: init_rom = 9'h11F; 6'd55: init_rom = 9'h120;
            6'd56: init_rom = 9'h123; 6'd57: init_rom = 9'h021; 6'd58: init_rom = 9'h029;
            default: init_rom = 9'h000;
        endcase
    endfunction

    function automatic logic [8:0] win_rom(input logic [5:0] i);
        case (i)
            6'd0:  win_rom = 9'h02A;          6'd1:  win_rom = {1'b1, XS[15:8]};
            6'd2:  win_rom = {1'b1, XS[7:0]}; 6'd3:  win_rom = {1'b1, XE[15:8]};
            6'd4:  win_rom = {1'b1, XE[7:0]}; 6'd5:  win_rom = 9'h02B;
            6'd6:  win_rom = {1'b1, YS[15:8]}; 6'd7: win_rom = {1'b1, YS[7:0]};
            6'd8:  win_rom = {1'b1, YE[15:8]}; 6'd9: win_rom = {1'b1, YE[7:0]};
            6'd10: win_rom = 9'h02C;
            default: win_rom = 9'h000;
        endcase
    endfunction

    logic [2:0]    state;
    logic [CW-1:0] dly;
    logic [5:0]    idx;
    logic [PW-1:0] pix_cnt;
    logic [2:0]    eph;
    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [14:0]   sh;
    logic          end_xfer;

    logic          eng_idle, stream_free, pix_accept, cmd_start, start;
    logic [8:0]    cmd_word;
    logic [15:0]   pix_word;

    assign eng_idle    = (eph == E_IDLE);
    assign stream_free = (state == STREAM) && eng_idle && (pix_cnt != PIX_TOTAL);
    assign frame_start = pix_accept && (pix_cnt == '0);
    assign start       = cmd_start || pix_accept;

`ifdef LCD_TEST_PATTERN_EN
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    logic [XW-1:0] tp_col;
    logic [YW-1:0] tp_row;
    logic          unused_tp;

    assign unused_tp  = ^{pix_data, pix_valid};
    assign pix_ready  = 1'b0;
    assign pix_accept = stream_free;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tp_col <= '0;
            tp_row <= '0;
        end else if (pix_accept) begin
            if (tp_col == XW'(H_RES - 1)) begin
                tp_col <= '0;
                tp_row <= (tp_row == YW'(V_RES - 1)) ? '0 : tp_row + 1'b1;
            end else begin
                tp_col <= tp_col + 1'b1;
            end
        end
    end

    always_comb begin
        pix_word = 16'h001F;
        if (tp_row < YW'(V_RES / 3))          pix_word = 16'hF800;
        else if (tp_row < YW'(2 * V_RES / 3)) pix_word = 16'h07E0;
    end
`else
    assign pix_ready  = stream_free;
    assign pix_accept = stream_free && pix_valid;
    assign pix_word   = pix_data;
`endif

    always_comb begin
        cmd_start = 1'b0;
        cmd_word  = 9'h000;
        if (eng_idle) begin
            case (state)
                WAKE:    if (idx == 6'd0)    begin cmd_start = 1'b1; cmd_word = 9'h011;        end
                INIT:    if (idx != INIT_LEN) begin cmd_start = 1'b1; cmd_word = init_rom(idx); end
                WINDOW:  if (idx != WIN_LEN)  begin cmd_start = 1'b1; cmd_word = win_rom(idx);  end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RST_HOLD;
            dly        <= '0;
            idx        <= '0;
            pix_cnt    <= '0;
            lcd_resetn <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                RST_HOLD: if (dly == RESET_LAST) begin
                    dly <= '0; lcd_resetn <= 1'b1; state <= RST_WAIT;
                end else dly <= dly + 1'b1;
                RST_WAIT: if (dly == PREPARE_LAST) begin
                    dly <= '0; state <= WAKE;
                end else dly <= dly + 1'b1;
                WAKE: if (eng_idle) begin
                    if (idx == 6'd0) idx <= 6'd1;
                    else begin idx <= '0; state <= SLEEP_WAIT; end
                end
                SLEEP_WAIT: if (dly == SLEEP_LAST) begin
                    dly <= '0; state <= INIT;
                end else dly <= dly + 1'b1;
                INIT: if (eng_idle) begin
                    if (idx != INIT_LEN) idx <= idx + 1'b1;
                    else begin idx <= '0; init_done <= 1'b1; state <= WINDOW; end
                end
                WINDOW: if (eng_idle) begin
                    if (idx != WIN_LEN) idx <= idx + 1'b1;
                    else begin idx <= '0; state <= STREAM; end
                end
                STREAM: if (pix_accept) pix_cnt <= pix_cnt + 1'b1;
                else if (eng_idle && pix_cnt == PIX_TOTAL) begin
                    pix_cnt <= '0; state <= WINDOW;
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

    // Bit engine: commands release CS after every byte; pixels keep CS low until the frame's last one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eph      <= E_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            end_xfer <= 1'b0;
            lcd_cs   <= 1'b1;
            lcd_rs   <= 1'b1;
            lcd_clk  <= 1'b0;
            lcd_data <= 1'b1;
        end else if (start) begin
            lcd_cs   <= 1'b0;
            lcd_rs   <= cmd_start ? cmd_word[8] : 1'b1;
            lcd_data <= cmd_start ? cmd_word[7] : pix_word[15];
            sh       <= cmd_start ? {cmd_word[6:0], 8'h00} : pix_word[14:0];
            bit_cnt  <= cmd_start ? 4'd7 : 4'd15;
            end_xfer <= cmd_start || (pix_cnt == PIX_LAST);
            div_cnt  <= '0;
            eph      <= E_LOW;
        end else if (eph != E_IDLE) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                case (eph)
                    E_LOW: begin
                        lcd_clk <= 1'b1;
                        eph     <= E_HIGH;
                    end
                    E_HIGH: begin
                        lcd_clk <= 1'b0;
                        if (bit_cnt == 4'd0) begin
                            eph <= end_xfer ? E_TAIL : E_IDLE;
                        end else begin
                            bit_cnt  <= bit_cnt - 1'b1;
                            lcd_data <= sh[14];
                            sh       <= {sh[13:0], 1'b0};
                            eph      <= E_LOW;
                        end
                    end
                    E_TAIL: begin
                        lcd_cs <= 1'b1;
                        eph    <= E_GAP;
                    end
                    default: eph <= E_IDLE;
                endcase
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_stream.sv
// Scoreboard bench for lcd_spi_stream: decodes MOSI on SCLK rises and compares bytes against queued expectations.
module tb_lcd_spi_stream;

    localparam int CLK_DIV = 2;
    localparam int H_RES   = 4;
    localparam int V_RES   = 2;
    localparam int CNT     = 4;

    logic        clk;
    logic        resetn;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready, frame_start, init_done;
    logic        lcd_resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data;

    int checks = 0;
    int errors = 0;

    logic [8:0] expq [$];
    logic [8:0] init_seq [60] = '{
        9'h011,
        9'h036, 9'h170, 9'h03A, 9'h105, 9'h0B2, 9'h10C, 9'h10C, 9'h100, 9'h133, 9'h133,
        9'h0B7, 9'h135, 9'h0BB, 9'h119, 9'h0C0, 9'h12C, 9'h0C2, 9'h101, 9'h0C3, 9'h112,
        9'h0C4, 9'h120, 9'h0C6, 9'h10F, 9'h0D0, 9'h1A4, 9'h1A1,
        9'h0E0, 9'h1D0, 9'h104, 9'h10D, 9'h111, 9'h113, 9'h12B, 9'h13F, 9'h154, 9'h14C,
        9'h118, 9'h10D, 9'h10B, 9'h11F, 9'h123,
        9'h0E1, 9'h1D0, 9'h104, 9'h10C, 9'h111, 9'h113, 9'h12C, 9'h13F, 9'h144, 9'h151,
        9'h12F, 9'h11F, 9'h11F, 9'h120, 9'h123,
        9'h021, 9'h029
    };
    logic [8:0] win_seq [11] = '{
        9'h02A, 9'h100, 9'h128, 9'h100, 9'h12B, 9'h02B, 9'h100, 9'h135, 9'h100, 9'h136, 9'h02C
    };

    int         cyc = 0;
    int         last_rise = 0;
    int         mon_bits = 0;
    int         byte_cnt = 0;
    logic       prev_sclk = 1'b0;
    logic       byte_rs = 1'b0;
    logic [7:0] shreg = '0;
    logic       in_frame = 1'b0;
    int         fs_cnt = 0;
    int         drv_cyc = 0;

    lcd_spi_stream #(
        .CLK_DIV(CLK_DIV), .H_RES(H_RES), .V_RES(V_RES), .X_OFS(40), .Y_OFS(53),
        .CNT_RESET(CNT), .CNT_PREPARE(CNT), .CNT_SLEEP(CNT)
    ) dut (
        .clk(clk), .resetn(resetn), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .frame_start(frame_start), .init_done(init_done),
        .lcd_resetn(lcd_resetn), .lcd_clk(lcd_clk), .lcd_cs(lcd_cs),
        .lcd_rs(lcd_rs), .lcd_data(lcd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_lcd_resetn", lcd_resetn, 1'b0);
        checkOutput("rst_lcd_cs", lcd_cs, 1'b1);
        checkOutput("rst_lcd_rs", lcd_rs, 1'b1);
        checkOutput("rst_lcd_clk", lcd_clk, 1'b0);
        checkOutput("rst_lcd_data", lcd_data, 1'b1);
        checkOutput("rst_pix_ready", pix_ready, 1'b0);
        checkOutput("rst_frame_start", frame_start, 1'b0);
        checkOutput("rst_init_done", init_done, 1'b0);
    endtask

    task automatic releaseReset();
        int n = 0;
        @(negedge clk);
        resetn = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (lcd_resetn) break;
        end
        checkOutput("lcd_resetn_low_cycles", n, CNT);
    endtask

    task automatic pushInit();
        foreach (init_seq[i]) expq.push_back(init_seq[i]);
        foreach (win_seq[i]) expq.push_back(win_seq[i]);
    endtask

    task automatic waitInitDone();
        int n = 0;
        while (!init_done && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("init_done_rise", init_done, 1'b1);
        checkOutput("bytes_at_init_done", byte_cnt, 60);
    endtask

    // Offers a pixel every third cycle; expectations are queued at the handshake.
    task automatic applyStimulus(input int n, input logic [15:0] base, input int first_idx);
        int sent = 0;
        int waited = 0;
        int pidx;
        while (sent < n) begin
            @(negedge clk);
            pix_valid = (drv_cyc % 3 == 0);
            pix_data  = base + 16'(sent) * 16'h1111;
            drv_cyc++;
            #1;
            if (pix_valid && pix_ready) begin
                pidx = first_idx + sent;
                checkOutput("frame_start_at_accept", frame_start, pidx == 0);
                if (frame_start) fs_cnt++;
                expq.push_back({1'b1, pix_data[15:8]});
                expq.push_back({1'b1, pix_data[7:0]});
                if (pidx == 0) in_frame = 1'b1;
                if (pidx == H_RES * V_RES - 1) begin
                    in_frame = 1'b0;
                    foreach (win_seq[i]) expq.push_back(win_seq[i]);
                end
                sent++;
                waited = 0;
            end else begin
                if (frame_start) fs_cnt++;
                waited++;
                if (waited > 1000) begin
                    checkOutput("pix_accept_timeout", 1, 0);
                    break;
                end
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    // SPI monitor: samples on the clk falling edge after each SCLK rise.
    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            mon_bits  = 0;
            byte_cnt  = 0;
            prev_sclk = 1'b0;
        end else begin
            if (lcd_clk && !prev_sclk) begin
                if (mon_bits != 0) begin
                    checkOutput("sclk_period", cyc - last_rise, 2 * CLK_DIV);
                    checkOutput("rs_stable", lcd_rs, byte_rs);
                end else begin
                    byte_rs = lcd_rs;
                end
                checkOutput("cs_low_at_rise", lcd_cs, 1'b0);
                shreg     = {shreg[6:0], lcd_data};
                last_rise = cyc;
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    byte_cnt++;
                    if (expq.size() == 0) checkOutput("unexpected_byte", {23'd0, byte_rs, shreg}, 32'h1FF);
                    else checkOutput("spi_byte", {byte_rs, shreg}, expq.pop_front());
                end
            end
            if (pix_ready) begin
                checkOutput("stall_sclk_low", lcd_clk, 1'b0);
                if (in_frame) checkOutput("stall_cs_low", lcd_cs, 1'b0);
            end
            if (!init_done) checkOutput("ready_before_init", pix_ready, 1'b0);
            prev_sclk = lcd_clk;
        end
    end

    initial begin
        int n;
        resetn    = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checkResetState();

        pushInit();
        releaseReset();
        waitInitDone();

        applyStimulus(H_RES * V_RES, 16'h1234, 0);
        checkOutput("frame_start_count_f1", fs_cnt, 1);
        n = 0;
        while (!lcd_cs && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("cs_high_after_frame", lcd_cs, 1'b1);

        applyStimulus(3, 16'hA5C3, 0);
        checkOutput("frame_start_count_f2", fs_cnt, 2);

        n = 0;
        while (mon_bits != 3 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("reached_bit5", mon_bits, 3);
        resetn = 1'b0;
        #1;
        checkResetState();
        expq.delete();
        in_frame = 1'b0;
        repeat (3) @(posedge clk);

        pushInit();
        releaseReset();
        waitInitDone();
        n = 0;
        while (byte_cnt < 71 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("bytes_after_restart", byte_cnt, 71);
        checkOutput("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
